// File: rtl/rom_loader.sv
// Loads a framed byte stream (A5, LEN_HI, LEN_LO, LEN words as HI/LO, XOR checksum) into the
// instruction ROM from address 0, and holds the CPU in reset until a frame loads cleanly.
module rom_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768,
  parameter int TIMEOUT   = 100000
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cpu_q, cpu_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              acc;
  logic [15:0]       len_new;

  // Ready whenever out of reset; the loader never back-pressures.
  assign rx_ready = reset;
  assign acc      = rx_valid & rx_ready;
  assign len_new  = {len_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cpu_d   = cpu_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (acc && rx_data == SYNC) begin
          state_d = S_LEN_HI;
          chk_d   = 8'h00;
          wcnt_d  = 16'd0;
          addr_d  = '0;
          tcnt_d  = 32'd0;
          busy_d  = 1'b1;
          cpu_d   = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = S_CHECK;
          end else if ({1'b0, len_new} > MAX_LEN) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (acc) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (acc) begin
          chk_d   = chk_q ^ rx_data;
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_W-1:0];
          wdata_d = {hi_q, rx_data};
          wcnt_d  = wcnt_q + 16'd1;
          state_d = (wcnt_q == len_q - 16'd1) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (acc) begin
          busy_d = 1'b0;
          if (rx_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cpu_d   = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inactivity watchdog: only runs while a frame is open; written words stay in the ROM.
    if (busy_q) begin
      if (acc) begin
        tcnt_d = 32'd0;
      end else if (tcnt_q == TO_LAST) begin
        state_d = S_ERR;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        cpu_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      hi_q    <= 8'h00;
      chk_q   <= 8'h00;
      wcnt_q  <= 16'd0;
      tcnt_q  <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'd0;
      cpu_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      chk_q   <= chk_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cpu_q   <= cpu_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_we    = we_q;
  assign rom_addr  = addr_q;
  assign rom_wdata = wdata_q;
  assign cpu_reset = cpu_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
